// File: rtl/data_bus_pkg.sv
// data_bus_pkg: size codes, controller FSM states and the byte-lane mask helper
// shared by data_bus_control and its bench.
package data_bus_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {CLEAR, IDLE, ACCESS} state_t;

    // An all-zero mask marks a misaligned access or the reserved size.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        return size == SZ_BYTE ? 4'b0001 << off :
               size == SZ_HALF ? (off[0] ? 4'b0000 : (off[1] ? 4'b1100 : 4'b0011)) :
               size == SZ_WORD ? (off == 2'b00 ? 4'b1111 : 4'b0000) : 4'b0000;
    endfunction
endpackage

// File: rtl/data_bus_control_if.sv
// data_bus_control_if: load/store request and response signals between the core
// (master) and the data bus controller (slave).
interface data_bus_control_if;
    logic        ready, busy, wd, rd, fault;
    logic [1:0]  size_in, size_out;
    logic [31:0] addr_in, addr_out, data_in, data_out;

    modport master (input ready, busy, data_out, fault,
                    output wd, rd, size_in, size_out, addr_in, addr_out, data_in);
    modport slave  (output ready, busy, data_out, fault,
                    input wd, rd, size_in, size_out, addr_in, addr_out, data_in);
endinterface

// File: rtl/dbc_byte_ram.sv
// dbc_byte_ram: single-port 2^AW x 32 RAM with per-byte write enables and a
// registered read.
module dbc_byte_ram #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [2**AW];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/data_bus_control.sv
// data_bus_control: data-side RAM controller with byte/half/word access and fault
// detection. Defining DBC_GPIO_EN adds a memory-mapped gpio_out register.
module data_bus_control
    import data_bus_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 8,
    parameter logic [31:0] GPIO_ADDR  = 32'h0001_0000
) (
    input  logic clk,
    input  logic rst,
`ifdef DBC_GPIO_EN
    output logic [31:0] gpio_out,
`endif
    data_bus_control_if.slave bus
);
`ifdef DBC_GPIO_EN
    localparam bit GPIO_EN = 1'b1;
`else
    localparam bit GPIO_EN = 1'b0;
`endif

    state_t                state_q, state_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d, ram_addr;
    logic                  ready_q, ready_d, busy_q, busy_d, fault_q, fault_d, wr_q, wr_d;
    logic [1:0]            size_q, size_d;
    logic [31:0]           addr_q, addr_d, wdata_q, wdata_d, data_out_q, data_out_d, gpio_q, gpio_d;
    logic [31:0]           ram_wdata, ram_rdata, src, lane_bits, shifted_wdata, loaded;
    logic [3:0]            mask, ram_we;
    logic [4:0]            sh;
    logic                  accept, gpio_hit, ram_hit, bad;

    assign accept        = state_q == IDLE && ready_q && !busy_q && (bus.wd || bus.rd);
    assign mask          = lane_mask(size_q, addr_q[1:0]);
    assign sh            = {addr_q[1:0], 3'b000};
    assign gpio_hit      = GPIO_EN && (addr_q[31:2] == GPIO_ADDR[31:2]);
    assign ram_hit       = (addr_q[31:DEPTH_LOG2+2] == '0) && !gpio_hit;
    assign bad           = mask == 4'b0000 || !(ram_hit || gpio_hit);
    assign lane_bits     = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    assign shifted_wdata = wdata_q << sh;
    assign src           = gpio_hit ? gpio_q : ram_rdata;
    assign loaded        = (src >> sh) & (lane_bits >> sh);

    // The load word is read while the request is accepted, so it is ready in ACCESS.
    assign ram_addr  = state_q == CLEAR  ? idx_q :
                       state_q == ACCESS ? addr_q[DEPTH_LOG2+1:2] : bus.addr_out[DEPTH_LOG2+1:2];
    assign ram_we    = !rst ? 4'b0000 :
                       state_q == CLEAR ? 4'b1111 :
                       (state_q == ACCESS && wr_q && ram_hit && !bad) ? mask : 4'b0000;
    assign ram_wdata = state_q == CLEAR ? '0 : shifted_wdata;

    dbc_byte_ram #(.AW(DEPTH_LOG2)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= CLEAR;
            idx_q      <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            fault_q    <= 1'b0;
            wr_q       <= 1'b0;
            size_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            data_out_q <= '0;
            gpio_q     <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            fault_q    <= fault_d;
            wr_q       <= wr_d;
            size_q     <= size_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            data_out_q <= data_out_d;
            gpio_q     <= gpio_d;
        end
    end

    always_comb begin
        state_d = state_q == CLEAR ? (idx_q == '1 ? IDLE : CLEAR) :
                  state_q == IDLE  ? (accept ? ACCESS : IDLE) : IDLE;
    end

    always_comb begin
        idx_d      = state_q == CLEAR ? idx_q + 1'b1 : idx_q;
        ready_d    = ready_q || (state_q == CLEAR && idx_q == '1);
        busy_d     = accept;
        fault_d    = state_q == ACCESS && bad;
        wr_d       = accept ? bus.wd : wr_q;
        size_d     = accept ? (bus.wd ? bus.size_in : bus.size_out) : size_q;
        addr_d     = accept ? (bus.wd ? bus.addr_in : bus.addr_out) : addr_q;
        wdata_d    = accept ? bus.data_in : wdata_q;
        data_out_d = (state_q == ACCESS && !wr_q && !bad) ? loaded : data_out_q;
        gpio_d     = (state_q == ACCESS && wr_q && gpio_hit && !bad) ?
                     (gpio_q & ~lane_bits) | (shifted_wdata & lane_bits) : gpio_q;
    end

    assign bus.ready    = ready_q;
    assign bus.busy     = busy_q;
    assign bus.fault    = fault_q;
    assign bus.data_out = data_out_q;
`ifdef DBC_GPIO_EN
    assign gpio_out = gpio_q;
`endif
endmodule

// File: tb/tb_data_bus_control.sv
// tb_data_bus_control: directed and randomized load/store traffic checked against
// a byte-array reference model of the data memory.
module tb_data_bus_control;
    import data_bus_pkg::*;

    localparam logic [31:0] GPIO_ADDR = 32'h0001_0000;
`ifdef DBC_GPIO_EN
    localparam bit GPIO_ON = 1'b1;
    logic [31:0] gpio_out;
`else
    localparam bit GPIO_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          checks = 0;
    int          passed = 0;
    logic [7:0]  mem_m [1024];
    logic [31:0] gpio_m = '0;
    logic [31:0] dout_m = '0;
    logic        b1, b2, f0, f1;
    logic [31:0] dq;

    data_bus_control_if bus();

    data_bus_control dut (
        .clk      (clk),
        .rst      (rst),
`ifdef DBC_GPIO_EN
        .gpio_out (gpio_out),
`endif
        .bus      (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic model_op(input bit w, input bit r, input logic [1:0] sz,
                            input logic [31:0] a, input logic [31:0] d, output bit flt);
        int  n;
        bit  gp;
        n   = 1 << sz;
        gp  = GPIO_ON && (a[31:2] == GPIO_ADDR[31:2]);
        flt = sz == 2'b11 || a % n != 0 || (a >= 1024 && !gp);
        if (flt) return;
        if (w) begin
            for (int i = 0; i < n; i++)
                if (gp) gpio_m[8*(a%4+i) +: 8] = d[8*i +: 8];
                else mem_m[a+i] = d[8*i +: 8];
        end else if (r) begin
            dout_m = '0;
            for (int i = 0; i < n; i++)
                dout_m[8*i +: 8] = gp ? gpio_m[8*(a%4+i) +: 8] : mem_m[a+i];
        end
    endtask

    task automatic clear_model;
        foreach (mem_m[i]) mem_m[i] = 8'h00;
        gpio_m = '0;
        dout_m = '0;
    endtask

    task automatic bus_op(input bit w, input bit r, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.wd       = w;
        bus.rd       = r;
        bus.size_in  = w ? sz : 2'($urandom);
        bus.size_out = w ? 2'($urandom) : sz;
        bus.addr_in  = w ? a : $urandom;
        bus.addr_out = w ? $urandom : a;
        bus.data_in  = d;
        @(posedge clk); #1;
        b1 = bus.busy;
        f0 = bus.fault;
        bus.wd = 1'b0;
        bus.rd = 1'b0;
        @(posedge clk); #1;
        b2 = bus.busy;
        f1 = bus.fault;
        dq = bus.data_out;
    endtask

    task automatic test_reset;
        int          first;
        logic [31:0] a;
        bit          ef;
        rst = 1'b0;
        bus.wd = 1'b0; bus.rd = 1'b0;
        bus.size_in = '0; bus.size_out = '0;
        bus.addr_in = '0; bus.addr_out = '0; bus.data_in = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", bus.ready); else passed++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else passed++;
        checks++; if (bus.fault !== 1'b0) $display("FAIL reset_fault: got %b want 0", bus.fault); else passed++;
        checks++; if (bus.data_out !== 32'h0) $display("FAIL reset_data_out: got %h want 0", bus.data_out); else passed++;
        @(negedge clk);
        rst = 1'b1;
        bus.rd = 1'b1;
        bus.addr_out = 32'h10;
        first = 0;
        for (int k = 1; k <= 300 && first == 0; k++) begin
            @(posedge clk); #1;
            if (bus.ready === 1'b1) first = k;
            if (first == 0 && bus.busy !== 1'b0) first = -k;
        end
        bus.rd = 1'b0;
        checks++; if (first != 256) $display("FAIL ready_rise_cycle: got %0d want 256", first); else passed++;
        clear_model();
        for (int i = 0; i < 4; i++) begin
            a = 32'($urandom_range(0, 255)) * 4;
            bus_op(1'b0, 1'b1, SZ_WORD, a, '0);
            model_op(1'b0, 1'b1, SZ_WORD, a, '0, ef);
            checks++; if (dq !== dout_m || f1 !== ef) $display("FAIL cleared_load @%h: got %h/%b want %h/%b", a, dq, f1, dout_m, ef); else passed++;
        end
    endtask

    task automatic test_directed;
        bit ef;
        bus_op(1'b1, 1'b0, SZ_WORD, 32'h10, 32'hDEADBEEF);
        model_op(1'b1, 1'b0, SZ_WORD, 32'h10, 32'hDEADBEEF, ef);
        checks++; if ({b1, b2, f0, f1} !== 4'b1000) $display("FAIL sw_busy_fault: got %b want 1000", {b1, b2, f0, f1}); else passed++;
        bus_op(1'b0, 1'b1, SZ_WORD, 32'h10, '0);
        model_op(1'b0, 1'b1, SZ_WORD, 32'h10, '0, ef);
        checks++; if ({b1, b2} !== 2'b10) $display("FAIL lw_busy: got %b want 10", {b1, b2}); else passed++;
        checks++; if (dq !== 32'hDEADBEEF) $display("FAIL lw_deadbeef: got %h want deadbeef", dq); else passed++;
        bus_op(1'b1, 1'b0, SZ_BYTE, 32'h13, 32'hAA);
        model_op(1'b1, 1'b0, SZ_BYTE, 32'h13, 32'hAA, ef);
        bus_op(1'b0, 1'b1, SZ_WORD, 32'h10, '0);
        model_op(1'b0, 1'b1, SZ_WORD, 32'h10, '0, ef);
        checks++; if (dq !== 32'hAAADBEEF) $display("FAIL sb_then_lw: got %h want aaadbeef", dq); else passed++;
        bus_op(1'b0, 1'b1, SZ_BYTE, 32'h13, '0);
        model_op(1'b0, 1'b1, SZ_BYTE, 32'h13, '0, ef);
        checks++; if (dq !== 32'h000000AA) $display("FAIL lbu_13: got %h want 000000aa", dq); else passed++;
        bus_op(1'b1, 1'b0, SZ_HALF, 32'h11, 32'h1234);
        model_op(1'b1, 1'b0, SZ_HALF, 32'h11, 32'h1234, ef);
        checks++; if ({b1, b2, f0, f1} !== 4'b1001) $display("FAIL sh_misaligned_fault: got %b want 1001", {b1, b2, f0, f1}); else passed++;
        bus_op(1'b0, 1'b1, SZ_WORD, 32'h10, '0);
        model_op(1'b0, 1'b1, SZ_WORD, 32'h10, '0, ef);
        checks++; if (dq !== 32'hAAADBEEF) $display("FAIL lw_after_fault: got %h want aaadbeef", dq); else passed++;
        bus_op(1'b0, 1'b1, SZ_WORD, 32'h400, '0);
        model_op(1'b0, 1'b1, SZ_WORD, 32'h400, '0, ef);
        checks++; if (f1 !== 1'b1) $display("FAIL lw_400_fault: got %b want 1", f1); else passed++;
        checks++; if (dq !== 32'hAAADBEEF) $display("FAIL lw_400_data_held: got %h want aaadbeef", dq); else passed++;
        bus_op(1'b1, 1'b0, SZ_WORD, GPIO_ADDR, 32'h0F);
        model_op(1'b1, 1'b0, SZ_WORD, GPIO_ADDR, 32'h0F, ef);
`ifdef DBC_GPIO_EN
        checks++; if (gpio_out !== 32'h0000000F || f1 !== 1'b0) $display("FAIL gpio_store: got %h/%b want 0000000f/0", gpio_out, f1); else passed++;
`else
        checks++; if (f1 !== 1'b1) $display("FAIL gpio_addr_fault: got %b want 1", f1); else passed++;
`endif
    endtask

    task automatic test_write_wins;
        bit ef;
        bus_op(1'b1, 1'b1, SZ_WORD, 32'h20, 32'h5);
        model_op(1'b1, 1'b1, SZ_WORD, 32'h20, 32'h5, ef);
        checks++; if (f1 !== 1'b0 || dq !== dout_m) $display("FAIL both_high_store: got %b/%h want 0/%h", f1, dq, dout_m); else passed++;
        bus_op(1'b0, 1'b1, SZ_WORD, 32'h20, '0);
        model_op(1'b0, 1'b1, SZ_WORD, 32'h20, '0, ef);
        checks++; if (dq !== 32'h5) $display("FAIL lw_20: got %h want 00000005", dq); else passed++;
    endtask

    task automatic test_back_to_back;
        logic [3:0] seen;
        bit         ef;
        @(negedge clk);
        bus.rd = 1'b1;
        bus.size_out = SZ_HALF;
        bus.addr_out = 32'h12;
        for (int k = 3; k >= 0; k--) begin
            @(posedge clk); #1;
            seen[k] = bus.busy;
        end
        @(negedge clk);
        bus.rd = 1'b0;
        model_op(1'b0, 1'b1, SZ_HALF, 32'h12, '0, ef);
        checks++; if (seen !== 4'b1010) $display("FAIL held_request_busy: got %b want 1010", seen); else passed++;
        checks++; if (bus.data_out !== dout_m) $display("FAIL held_request_data: got %h want %h", bus.data_out, dout_m); else passed++;
        @(posedge clk); #1;
        checks++; if (bus.busy !== 1'b0) $display("FAIL released_request_idle: got %b want 0", bus.busy); else passed++;
    endtask

    task automatic test_random;
        bit          w, r, ef;
        logic [1:0]  sz;
        logic [31:0] a, d;
        int          bad_busy, bad_fault, bad_data;
        bad_busy = 0; bad_fault = 0; bad_data = 0;
        for (int n = 0; n < 300; n++) begin
            w  = 1'($urandom_range(0, 1));
            r  = w ? 1'($urandom_range(0, 1)) : 1'b1;
            sz = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0:       a = 32'h400 + 32'($urandom_range(0, 255));
                1:       a = $urandom;
                2, 3, 4: a = 32'($urandom_range(0, 63));
                default: a = 32'($urandom_range(0, 1023));
            endcase
            d = $urandom;
            bus_op(w, r, sz, a, d);
            model_op(w, r, sz, a, d, ef);
            checks++; if ({b1, b2, f0} !== 3'b100) begin
                if (bad_busy++ < 5) $display("FAIL rand_busy op%0d: got %b want 100", n, {b1, b2, f0});
            end else passed++;
            checks++; if (f1 !== ef) begin
                if (bad_fault++ < 5) $display("FAIL rand_fault op%0d sz%0d @%h: got %b want %b", n, sz, a, f1, ef);
            end else passed++;
            checks++; if (dq !== dout_m) begin
                if (bad_data++ < 5) $display("FAIL rand_data op%0d sz%0d @%h: got %h want %h", n, sz, a, dq, dout_m);
            end else passed++;
        end
    endtask

    task automatic test_mid_reset;
        int first;
        bit ef;
        bus_op(1'b1, 1'b0, SZ_WORD, 32'h40, 32'h12345678);
        model_op(1'b1, 1'b0, SZ_WORD, 32'h40, 32'h12345678, ef);
        @(negedge clk);
        bus.wd = 1'b1;
        bus.size_in = SZ_WORD;
        bus.addr_in = 32'h44;
        bus.data_in = 32'hCAFEF00D;
        @(posedge clk); #1;
        checks++; if (bus.busy !== 1'b1) $display("FAIL mid_reset_started: got %b want 1", bus.busy); else passed++;
        bus.wd = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if ({bus.busy, bus.ready, bus.fault} !== 3'b000) $display("FAIL mid_reset_abort: got %b want 000", {bus.busy, bus.ready, bus.fault}); else passed++;
        checks++; if (bus.data_out !== 32'h0) $display("FAIL mid_reset_data_out: got %h want 0", bus.data_out); else passed++;
        @(negedge clk);
        rst = 1'b1;
        first = 0;
        for (int k = 1; k <= 400 && first == 0; k++) begin
            @(posedge clk); #1;
            if (bus.ready === 1'b1) first = k;
        end
        checks++; if (first != 256) $display("FAIL reclear_ready_cycle: got %0d want 256", first); else passed++;
        clear_model();
        bus_op(1'b0, 1'b1, SZ_WORD, 32'h40, '0);
        checks++; if (dq !== 32'h0) $display("FAIL reclear_lw_40: got %h want 0", dq); else passed++;
        bus_op(1'b0, 1'b1, SZ_WORD, 32'h44, '0);
        checks++; if (dq !== 32'h0) $display("FAIL reclear_lw_44: got %h want 0", dq); else passed++;
        bus_op(1'b0, 1'b1, SZ_WORD, 32'h10, '0);
        checks++; if (dq !== 32'h0) $display("FAIL reclear_lw_10: got %h want 0", dq); else passed++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_write_wins();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
